// File: rtl/seg_count_rx.sv
`default_nettype none
// ============================================================================
// Module   : seg_count_rx
// Brief    : Receives an asynchronous 7-segment pattern and debounces it into
//            a stable value. It decodes that value as a 0..3 count and delivers
//            it through a valid/ready handshake. Illegal patterns and
//            overwritten counts are flagged.
// Revision : 1.0 - initial release
// ============================================================================
module seg_count_rx #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic       clr,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] count,
    output logic       err,
    output logic       illegal_sticky,
    output logic       overrun_sticky
);

    localparam int unsigned   c_CNT_W   = 8;
    localparam logic [7:0]    c_STABLE  = c_CNT_W'(STABLE_CYCLES);
    localparam logic [7:0]    c_CNT_ONE = 8'd1;

    // Legal segment codes, {a,b,c,d,e,f,g}
    localparam logic [6:0]    c_PAT_0   = 7'b1110001;
    localparam logic [6:0]    c_PAT_1   = 7'b1101101;
    localparam logic [6:0]    c_PAT_2   = 7'b0110000;
    localparam logic [6:0]    c_PAT_3   = 7'b0000001;

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [7:0] r_cnt;
    logic       r_qual;
    logic [6:0] r_last;
    logic       r_valid;
    logic [1:0] r_count;
    logic       r_err;
    logic       r_ill;
    logic       r_ovr;

    logic       w_change;
    logic [7:0] w_cnt_next;
    logic       w_qual_next;
    logic       w_legal;
    logic [1:0] w_dec;
    logic       w_event;
    logic       w_load;
    logic       w_bad;
    logic       w_accept;
    logic       w_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= seg;
            r_sync2 <= r_sync1;
        end
    end

    // The counter tracks how long r_sync2 has held. Looking one stage ahead
    // (r_sync1) lets the qualify flag line up with the cycle the count
    // first reaches STABLE_CYCLES, so the output lands without an extra cycle.
    assign w_change = (r_sync1 != r_sync2);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_change) begin
            w_cnt_next = c_CNT_ONE;
        end else if (r_cnt != c_STABLE) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end
    end

    assign w_qual_next = (w_cnt_next == c_STABLE) && (w_change || (r_cnt != c_STABLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_qual <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_qual <= w_qual_next;
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 2'd0;
        case (r_sync2)
            c_PAT_0: w_dec = 2'd0;
            c_PAT_1: w_dec = 2'd1;
            c_PAT_2: w_dec = 2'd2;
            c_PAT_3: w_dec = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_event   = r_qual && (r_sync2 != r_last);
    assign w_load    = w_event && w_legal;
    assign w_bad     = w_event && !w_legal;
    assign w_accept  = r_valid && out_ready;
    assign w_overrun = w_load && r_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_event) begin
                r_last <= r_sync2;
            end
            // A load in the same cycle as a handshake keeps valid high.
            if (w_load) begin
                r_valid <= 1'b1;
                r_count <= w_dec;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    // A set in the same cycle as clr wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_ill <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_err <= w_bad;
            r_ill <= w_bad | (r_ill & ~clr);
            r_ovr <= w_overrun | (r_ovr & ~clr);
        end
    end

    assign out_valid      = r_valid;
    assign count          = r_count;
    assign err            = r_err;
    assign illegal_sticky = r_ill;
    assign overrun_sticky = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_seg_count_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_count_rx
// Brief    : Scenario tasks plus a randomized run for seg_count_rx. They are
//            compared against a run-length / lookup-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_count_rx;

    localparam int STABLE = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [6:0] seg       = 7'd0;
    logic       clr       = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] count;
    logic       err;
    logic       illegal_sticky;
    logic       overrun_sticky;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [6:0] m_hist[$];
    int         m_run;
    logic [6:0] m_last;
    logic       m_valid;
    logic [1:0] m_count;
    logic       m_err;
    logic       m_ill;
    logic       m_ovr;

    logic [6:0] legal_pats [4] = '{7'b1110001, 7'b1101101, 7'b0110000, 7'b0000001};

    seg_count_rx #(.STABLE_CYCLES(STABLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .seg            (seg),
        .clr            (clr),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .count          (count),
        .err            (err),
        .illegal_sticky (illegal_sticky),
        .overrun_sticky (overrun_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dut_vec();
        return {out_valid, count, err, illegal_sticky, overrun_sticky};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_valid, m_count, m_err, m_ill, m_ovr};
    endfunction

    // Returns {legal, value}
    function automatic logic [2:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 4; k++) begin
            if (legal_pats[k] == p) return {1'b1, 2'(k)};
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_hist  = '{7'd0, 7'd0};
        m_run   = 0;
        m_last  = 7'd0;
        m_valid = 1'b0;
        m_count = 2'd0;
        m_err   = 1'b0;
        m_ill   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One rising edge of behaviour: the pattern that has been seen for
    // exactly STABLE cycles is judged, then the two-edge-delayed view advances.
    task automatic model_edge();
        logic [6:0] s_now;
        logic [2:0] d;
        logic       ev;
        logic       ov;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_now = m_hist[m_hist.size() - 2];
        d     = ref_decode(s_now);
        ev    = (m_run == STABLE) && (s_now != m_last);
        if (ev) m_last = s_now;
        m_err = ev && !d[2];
        ov    = ev && d[2] && m_valid && !out_ready;
        if (ev && d[2]) begin
            m_valid = 1'b1;
            m_count = d[1:0];
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        m_ill = m_err || (m_ill && !clr);
        m_ovr = ov || (m_ovr && !clr);
        m_hist.push_back(seg);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        if (m_hist[m_hist.size() - 2] == s_now) begin
            if (m_run < 100000) m_run++;
        end else begin
            m_run = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        seg       = 7'd0;
        clr       = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", dut_vec(), 6'b0);
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat = -1;
        seg       = 7'b1110001;
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid === 1'b1 && lat < 0) lat = i;
        end
        checks++;
        if (lat != STABLE + 2) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", lat, STABLE + 2);
        end
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL count0: got %0d expected 0", count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_steps();
        logic [1:0] got[$];
        logic [6:0] pats [2] = '{7'b1101101, 7'b0000001};
        out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            seg = pats[p];
            for (int i = 0; i < 10; i++) begin
                tick();
                if (out_valid && out_ready) got.push_back(count);
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 2'd1 || got[1] !== 2'd3) begin
            errors++;
            $display("FAIL steps_transfers: got %0d transfers first=%0d expected 2 transfers 1 then 3",
                     got.size(), (got.size() > 0) ? got[0] : 2'd0);
        end
        checks++;
        if ({illegal_sticky, overrun_sticky} !== 2'b00) begin
            errors++;
            $display("FAIL steps_stickies: got %b expected 00", {illegal_sticky, overrun_sticky});
        end
    endtask

    task automatic test_glitch();
        int n_err   = 0;
        int n_valid = 0;
        int last_cnt = -1;
        out_ready = 1'b1;
        seg = 7'b0110000;
        for (int i = 0; i < 10; i++) tick();
        seg = 7'b1111111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_err += int'(err); n_valid += int'(out_valid);
        end
        seg = 7'b0110000;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_err += int'(err); n_valid += int'(out_valid);
        end
        checks++;
        if (n_err != 0 || n_valid != 0 || illegal_sticky !== 1'b0) begin
            errors++;
            $display("FAIL short_glitch: got err=%0d valid=%0d ill=%b expected 0 0 0",
                     n_err, n_valid, illegal_sticky);
        end
        seg = 7'b1111111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_err += int'(err);
        end
        seg = 7'b0110000;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_err += int'(err);
            if (out_valid) last_cnt = int'(count);
        end
        checks++;
        if (n_err != 1 || illegal_sticky !== 1'b1) begin
            errors++;
            $display("FAIL long_glitch: got err pulses=%0d ill=%b expected 1 1", n_err, illegal_sticky);
        end
        checks++;
        if (last_cnt != 2) begin
            errors++;
            $display("FAIL glitch_return: got count=%0d expected 2", last_cnt);
        end
    endtask

    task automatic test_overrun_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (illegal_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_illegal: got %b expected 0", illegal_sticky);
        end
        out_ready = 1'b0;
        seg = 7'b1101101;
        for (int i = 0; i < 10; i++) tick();
        seg = 7'b0110000;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({out_valid, count, overrun_sticky} !== {1'b1, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL overrun: got v=%b c=%0d ovr=%b expected 1 2 1", out_valid, count, overrun_sticky);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({out_valid, overrun_sticky} !== 2'b10) begin
            errors++;
            $display("FAIL clr_overrun: got v=%b ovr=%b expected 1 0", out_valid, overrun_sticky);
        end
    endtask

    task automatic test_reset_mid();
        int lat = -1;
        seg = 7'b1101101;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", dut_vec(), 6'b0);
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid === 1'b1 && lat < 0) lat = i;
        end
        checks++;
        if (lat != STABLE + 2 || count !== 2'd1) begin
            errors++;
            $display("FAIL resume: got latency=%0d count=%0d expected %0d and 1", lat, count, STABLE + 2);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        seg = 7'b0000001;
        for (int i = 0; i < STABLE + 1; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, count, overrun_sticky} !== {1'b1, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL handshake_load: got v=%b c=%0d ovr=%b expected 1 3 0", out_valid, count, overrun_sticky);
        end
        seg = 7'b1110001;
        for (int i = 0; i < STABLE + 1; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if ({out_valid, count, overrun_sticky} !== {1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL clr_vs_overrun: got v=%b c=%0d ovr=%b expected 1 0 1", out_valid, count, overrun_sticky);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_model: got %b expected %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int hold;
        int bad = 0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0) seg = legal_pats[$urandom_range(0, 3)];
            else                           seg = 7'($urandom);
            hold = $urandom_range(1, STABLE + 4);
            for (int i = 0; i < hold; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                clr       = ($urandom_range(0, 15) == 0);
                tick();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL random_cycle: got {v,c,e,i,o}=%b expected %b", dut_vec(), exp_vec());
                    bad++;
                end
            end
        end
        clr       = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_latency();
        test_steps();
        test_glitch();
        test_overrun_clr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_count_rx.md
SEG_COUNT_RX -- requirements
Module: seg_count_rx

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, legal range 1..255: consecutive synchronized cycles a pattern must hold to qualify.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port seg  input  7  segment pattern {a,b,c,d,e,f,g}, seg[6]=a ... seg[0]=g, asynchronous to clk.
REQ-005 SHALL have port clr  input  1  synchronous clear of sticky flags.
REQ-006 SHALL have port out_ready  input  1  consumer accepts count when high with out_valid.
REQ-007 SHALL have port out_valid  output  1  count holds an unaccepted decoded value.
REQ-008 SHALL have port count  output  2  decoded ones-count value 0..3.
REQ-009 SHALL have port err  output  1  one-cycle pulse on qualified illegal pattern.
REQ-010 SHALL have port illegal_sticky  output  1  set by any err pulse, held until clr.
REQ-011 SHALL have port overrun_sticky  output  1  set when an unaccepted value is overwritten, held until clr.

Function
REQ-012 SHALL pass seg through a 2-flop synchronizer; s denotes the second-stage value.
REQ-013 SHALL keep stability counter cnt: load 1 when s differs from its previous-cycle value; else increment, saturating at STABLE_CYCLES.
REQ-014 SHALL qualify s only on the cycle cnt first reaches STABLE_CYCLES; shorter glitches SHALL produce no output activity.
REQ-015 SHALL treat a qualified pattern as an event only if it differs from last_pat (register, updated to s on every event).
REQ-016 SHALL decode legal patterns: 7'b1110001->0, 7'b1101101->1, 7'b0110000->2, 7'b0000001->3; all other 124 codes SHALL be illegal.
REQ-017 On a legal event SHALL register count and assert out_valid on the next edge; latency SHALL be exactly STABLE_CYCLES+2 rising edges counted from the first edge sampling the new seg.
REQ-018 On an illegal event SHALL pulse err for exactly one cycle, set illegal_sticky, leave count and out_valid unchanged.
REQ-019 out_valid SHALL stay high and count SHALL stay stable until a cycle with out_valid and out_ready both high; out_valid SHALL then drop next edge unless a new legal event loads in the same cycle.
REQ-020 Legal event while out_valid high and out_ready low SHALL overwrite count, keep out_valid high, set overrun_sticky.
REQ-021 Legal event in the same cycle as a handshake SHALL count as accepted old data, load new count, keep out_valid high, no overrun.
REQ-022 clr SHALL zero both stickies next edge; simultaneous set and clr SHALL leave the sticky set.
REQ-023 Re-qualifying the pattern equal to last_pat (e.g., after a rejected glitch) SHALL produce no event.
REQ-024 out_ready while out_valid low SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force out_valid=0, count=0, err=0, illegal_sticky=0, overrun_sticky=0, cnt=0, synchronizer flops=0, last_pat=7'b0000000 (illegal, so first qualified legal pattern, including count 0, is an event).
REQ-026 rst_n low mid-operation SHALL discard pending out_valid and any partial qualification; operation SHALL resume from the first edge after rst_n rises.

Verification
REQ-027 STABLE_CYCLES=4, reset then seg=7'b1110001 held -> out_valid=1, count=0 after 6th edge; out_ready=1 one cycle -> out_valid=0 next edge.
REQ-028 seg steps 7'b1101101 to 7'b0000001, each held 10 cycles, out_ready=1 -> two transfers, count=1 then 3, no stickies.
REQ-029 Stable 7'b0110000, 3-cycle glitch to 7'b1111111, return -> no err, no new out_valid; glitch held 4 cycles -> one err pulse, illegal_sticky=1, then return to 7'b0110000 yields new event count=2.
REQ-030 out_ready=0, legal patterns 1 then 2 qualified -> count=2, out_valid=1, overrun_sticky=1; clr pulse -> overrun_sticky=0.
REQ-031 rst_n asserted 3 cycles into qualification of 7'b1101101 -> all outputs 0 at once; after release, pattern still held -> out_valid with count=1 after 6 edges.
REQ-032 Handshake coincident with new legal event, and clr coincident with overrun -> out_valid stays 1 with new count; overrun_sticky=1 only in the second case.
